// File: rtl/pooler_multimode.sv
// Streaming non-overlapping PxP max/average pooling over a raster-scan feature map.
// Per-column-window accumulators stand in for full line buffers.
module pooler_multimode #(
   parameter int DATA_W = 32,
   parameter int M_W    = 4,
   parameter int M_H    = 4,
   parameter int P      = 2
) (
   input  logic              clk,
   input  logic              master_rst,
   input  logic              ce,
   input  logic              in_valid,
   input  logic              mode,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_op,
   output logic              end_op
);
   localparam int LP    = $clog2(P);
   localparam int ACC_W = DATA_W + 2*LP;
   localparam int N_WIN = M_W / P;
   localparam int ACT_W = N_WIN * P;
   localparam int ACT_H = (M_H / P) * P;
   localparam int CW    = $clog2(M_W);
   localparam int RW    = $clog2(M_H);
   localparam int WW    = (N_WIN > 1) ? $clog2(N_WIN) : 1;

   logic [CW-1:0]           col_q;
   logic [RW-1:0]           row_q;
   logic                    mode_q;
   logic signed [ACC_W-1:0] acc_mem [N_WIN];

   logic                    accept, first_px, mode_eff, active;
   logic                    win_first, win_last, frame_last;
   logic [WW-1:0]           win_idx;
   logic signed [ACC_W-1:0] px_ext, acc_cur, acc_new;
   logic [DATA_W-1:0]       avg_res;

   always_comb begin
      accept     = ce && in_valid;
      first_px   = (col_q == '0) && (row_q == '0);
      // Pixel (0,0) uses the live mode input because the latch updates on that same edge.
      mode_eff   = first_px ? mode : mode_q;
      active     = (int'(col_q) < ACT_W) && (int'(row_q) < ACT_H);
      win_first  = (col_q[LP-1:0] == '0) && (row_q[LP-1:0] == '0);
      win_last   = (&col_q[LP-1:0]) && (&row_q[LP-1:0]);
      frame_last = (int'(col_q) == ACT_W-1) && (int'(row_q) == ACT_H-1);
      win_idx    = WW'(col_q >> LP);
      px_ext     = {{(2*LP){data_in[DATA_W-1]}}, data_in};
      acc_cur    = acc_mem[win_idx];
      if (win_first) begin
         acc_new = px_ext;
      end else if (mode_eff) begin
         acc_new = acc_cur + px_ext;
      end else begin
         acc_new = (px_ext > acc_cur) ? px_ext : acc_cur;
      end
      avg_res    = DATA_W'(acc_new >>> (2*LP));
   end

   always_ff @(posedge clk or posedge master_rst) begin
      if (master_rst) begin
         col_q    <= '0;
         row_q    <= '0;
         mode_q   <= 1'b0;
         data_out <= '0;
         valid_op <= 1'b0;
         end_op   <= 1'b0;
      end else begin
         valid_op <= 1'b0;
         end_op   <= 1'b0;
         if (accept) begin
            if (first_px) begin
               mode_q <= mode;
            end
            if (col_q == CW'(M_W-1)) begin
               col_q <= '0;
               row_q <= (row_q == RW'(M_H-1)) ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
            if (active && win_last) begin
               data_out <= mode_eff ? avg_res : acc_new[DATA_W-1:0];
               valid_op <= 1'b1;
               end_op   <= frame_last;
            end
         end
      end
   end

   // Buffer contents need no reset: every window starts by overwriting its entry.
   always_ff @(posedge clk) begin
      if (accept && active) begin
         acc_mem[win_idx] <= acc_new;
      end
   end
endmodule

// File: tb/tb_pooler_multimode.sv
// Bench for pooler_multimode: table vectors, hand-written reset/border sequences and
// random frames against a window-level reference model, on a 4x4 and a 5x5 instance.
module tb_pooler_multimode;
   localparam int DW = 32;
   localparam int PP = 2;

   typedef struct {
      longint val;
      bit     last;
      int     cyc;
   } rec_t;

   typedef struct {
      bit md;
      int base;
      int step;
      int exp_v[4];
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ce = 1'b0;
   logic          iv_a = 1'b0;
   logic          iv_b = 1'b0;
   logic          mode = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout_a, dout_b;
   logic          val_a, val_b, end_a, end_b;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   stray_end = 0;
   int   px[$];
   int   acc_cyc[$];
   rec_t exp_q[$];
   rec_t obs_a[$];
   rec_t obs_b[$];

   pooler_multimode #(.DATA_W(DW), .M_W(4), .M_H(4), .P(PP)) dut_a (
      .clk(clk), .master_rst(rst), .ce(ce), .in_valid(iv_a), .mode(mode),
      .data_in(din), .data_out(dout_a), .valid_op(val_a), .end_op(end_a));

   pooler_multimode #(.DATA_W(DW), .M_W(5), .M_H(5), .P(PP)) dut_b (
      .clk(clk), .master_rst(rst), .ce(ce), .in_valid(iv_b), .mode(mode),
      .data_in(din), .data_out(dout_b), .valid_op(val_b), .end_op(end_b));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (val_a) obs_a.push_back('{$signed(dout_a), end_a, cyc});
      if (val_b) obs_b.push_back('{$signed(dout_b), end_b, cyc});
      if (end_a && !val_a) stray_end++;
      if (end_b && !val_b) stray_end++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int last_idx(input int k, input int w);
      int nw, wr, wc;
      nw = w / PP;
      wr = k / nw;
      wc = k % nw;
      return (wr*PP + PP-1)*w + wc*PP + PP-1;
   endfunction

   // Streams px[] into one instance; idle cycles (ce or in_valid low) are sprinkled in when gate is set.
   // Mode is inverted on every pixel but the first to prove it is only sampled at (0,0).
   task automatic drive_frame(input bit sel, input bit md, input bit gate);
      acc_cyc.delete();
      for (int i = 0; i < px.size(); i++) begin
         if (gate) begin
            for (int k = 0; k < 4 && $urandom_range(0, 2) == 0; k++) begin
               @(negedge clk);
               case ($urandom_range(0, 2))
                  0:       begin ce = 1'b0; iv_a = !sel; iv_b = sel; end
                  1:       begin ce = 1'b1; iv_a = 1'b0; iv_b = 1'b0; end
                  default: begin ce = 1'b0; iv_a = 1'b0; iv_b = 1'b0; end
               endcase
               din  = $urandom;
               mode = 1'($urandom);
            end
         end
         @(negedge clk);
         ce   = 1'b1;
         iv_a = !sel;
         iv_b = sel;
         din  = px[i];
         mode = (i == 0) ? md : !md;
         acc_cyc.push_back(cyc + 1);
      end
      @(negedge clk);
      ce   = 1'b0;
      iv_a = 1'b0;
      iv_b = 1'b0;
   endtask

   // Window-level reference: max or floor(sum / P^2) over each full PxP block of the frame.
   task automatic build_model(input int w, input int h, input bit md);
      int     nw, nh, v, li;
      longint acc, q;
      nw = w / PP;
      nh = h / PP;
      exp_q.delete();
      for (int wr = 0; wr < nh; wr++) begin
         for (int wc = 0; wc < nw; wc++) begin
            acc = md ? 0 : px[(wr*PP)*w + wc*PP];
            for (int r = 0; r < PP; r++) begin
               for (int c = 0; c < PP; c++) begin
                  v = px[(wr*PP + r)*w + wc*PP + c];
                  if (md) acc += v;
                  else if (v > acc) acc = v;
               end
            end
            if (md) begin
               q = acc / (PP*PP);
               if ((acc % (PP*PP)) != 0 && acc < 0) q -= 1;
               acc = q;
            end
            li = last_idx(wr*nw + wc, w);
            exp_q.push_back('{acc, (wr == nh-1) && (wc == nw-1), acc_cyc[li]});
         end
      end
   endtask

   task automatic compare(input bit sel, input string tag);
      rec_t got[$];
      repeat (3) @(negedge clk);
      if (sel) got = obs_b;
      else     got = obs_a;
      chk($sformatf("%s count", tag), got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         chk($sformatf("%s val[%0d]", tag, i), got[i].val, exp_q[i].val);
         chk($sformatf("%s end[%0d]", tag, i), got[i].last, exp_q[i].last);
         chk($sformatf("%s cycle[%0d]", tag, i), got[i].cyc, exp_q[i].cyc);
      end
      obs_a.delete();
      obs_b.delete();
      exp_q.delete();
   endtask

   initial begin
      vec_t tbl[4];
      bit   md;
      tbl[0].md = 1'b0; tbl[0].base = 0;  tbl[0].step = 1;  tbl[0].exp_v = '{5, 7, 13, 15};
      tbl[1].md = 1'b1; tbl[1].base = 0;  tbl[1].step = 1;  tbl[1].exp_v = '{2, 4, 10, 12};
      tbl[2].md = 1'b1; tbl[2].base = -1; tbl[2].step = -1; tbl[2].exp_v = '{-4, -6, -12, -14};
      tbl[3].md = 1'b0; tbl[3].base = -1; tbl[3].step = -1; tbl[3].exp_v = '{-1, -3, -9, -11};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset data_out a", dout_a, 0);
      chk("reset valid_op a", val_a, 0);
      chk("reset end_op a", end_a, 0);
      chk("reset data_out b", dout_b, 0);
      chk("reset valid_op b", val_b, 0);
      chk("reset end_op b", end_b, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 4; t++) begin
         px.delete();
         for (int i = 0; i < 16; i++) px.push_back(tbl[t].base + tbl[t].step*i);
         drive_frame(1'b0, tbl[t].md, 1'b0);
         exp_q.delete();
         for (int k = 0; k < 4; k++)
            exp_q.push_back('{tbl[t].exp_v[k], k == 3, acc_cyc[last_idx(k, 4)]});
         compare(1'b0, $sformatf("table%0d", t));
      end

      for (int f = 0; f < 2; f++) begin
         px.delete();
         for (int i = 0; i < 16; i++) px.push_back(i);
         drive_frame(1'b0, 1'b0, 1'b1);
         build_model(4, 4, 1'b0);
         compare(1'b0, $sformatf("gated%0d", f));
      end

      for (int f = 0; f < 6; f++) begin
         px.delete();
         for (int i = 0; i < 16; i++)
            px.push_back((f % 2 == 0) ? int'($urandom) : $urandom_range(0, 6) - 3);
         md = 1'($urandom);
         drive_frame(1'b0, md, 1'b1);
         build_model(4, 4, md);
         compare(1'b0, $sformatf("rand_a%0d", f));
      end

      px.delete();
      for (int i = 0; i < 7; i++) px.push_back(i);
      drive_frame(1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset data_out", dout_a, 0);
      chk("midreset valid_op", val_a, 0);
      chk("midreset end_op", end_a, 0);
      rst = 1'b0;
      obs_a.delete();
      obs_b.delete();
      px.delete();
      for (int i = 0; i < 16; i++) px.push_back(i);
      drive_frame(1'b0, 1'b0, 1'b0);
      exp_q.delete();
      for (int k = 0; k < 4; k++)
         exp_q.push_back('{tbl[0].exp_v[k], k == 3, acc_cyc[last_idx(k, 4)]});
      compare(1'b0, "after_reset");

      px.delete();
      for (int i = 0; i < 25; i++) px.push_back(i);
      drive_frame(1'b1, 1'b0, 1'b0);
      exp_q.push_back('{6,  1'b0, acc_cyc[6]});
      exp_q.push_back('{8,  1'b0, acc_cyc[8]});
      exp_q.push_back('{16, 1'b0, acc_cyc[16]});
      exp_q.push_back('{18, 1'b1, acc_cyc[18]});
      compare(1'b1, "border5");

      for (int f = 0; f < 3; f++) begin
         px.delete();
         for (int i = 0; i < 25; i++) px.push_back(int'($urandom));
         md = 1'($urandom);
         drive_frame(1'b1, md, 1'b1);
         build_model(5, 5, md);
         compare(1'b1, $sformatf("rand_b%0d", f));
      end

      chk("stray end_op", stray_end, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pooler_multimode.md
Name: pooler_multimode

Overview:
Parametrised streaming 2-D pooling engine for the CNN datapath. It sits between the convolver/activation stage and the next layer's buffer. It accepts one raster-scan feature-map pixel per accepted cycle and emits one pooled value per non-overlapping PxP window, in max or average mode. Map width, height, pool size and data width are parameters. A per-column partial-result buffer of M_W/P entries replaces full line buffers.

Parameters:
DATA_W, 32, signed two's-complement pixel width.
M_W, 4, input feature-map width in pixels (>= P).
M_H, 4, input feature-map height in pixels (>= P).
P, 2, pool window size (PxP); must be a power of two >= 2; stride fixed = P.

Ports:
clk  in  1  clock, rising edge.
master_rst  in  1  asynchronous active-high reset.
ce  in  1  clock enable; when low no pixel is accepted and counters hold.
in_valid  in  1  data_in carries a pixel this cycle.
mode  in  1  0 = max, 1 = average; sampled only on the first pixel of a frame.
data_in  in  DATA_W  signed input pixel.
data_out  out  DATA_W  pooled result; held between results.
valid_op  out  1  one-cycle pulse: data_out is new.
end_op  out  1  one-cycle pulse coincident with the last valid_op of a frame.

Behaviour:
- Reset: async assert zeroes data_out, valid_op, end_op, row/column counters and the mode latch; buffer contents are don't-care. Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- Accept = ce && in_valid. Only accepted pixels advance col (0..M_W-1, wraps, increments row) and row (0..M_H-1, wraps to new frame).
- Active region: col < (M_W/P)*P and row < (M_H/P)*P. Pixels outside it are accepted, counted and discarded.
- Window index = col/P. Buffer entry width is DATA_W + 2*log2(P) (sum headroom).
- First pixel of a window (row%P==0 && col%P==0) overwrites the entry. Every other pixel in the window combines into it: max = signed compare keep larger; avg = signed add.
- Mode is latched at pixel (0,0) of each frame and is constant for the whole frame.
- Last pixel of a window (row%P==P-1 && col%P==P-1): the result is registered into data_out and valid_op pulses high on the next clock edge (latency 1 cycle). Max result = entry. Avg result = entry arithmetic-shifted right by 2*log2(P) (floor toward -inf), truncated to DATA_W.
- valid_op/end_op are single-cycle pulses regardless of ce on the following cycle.
- end_op pulses with the result of window (M_H/P-1, M_W/P-1), even if discarded border pixels follow.
- No backpressure: the consumer must take every valid_op pulse.
- ce low mid-window freezes state indefinitely with no corruption.

Test Plan:
1. Defaults, mode=0, in_valid=1, ce=1, data_in = 0..15 -> valid_op with data_out = 5, 7, 13, 15, each the cycle after pixels 5/7/13/15 are accepted; end_op only with 15.
2. Defaults, mode=1, data_in = 0..15 -> 2, 4, 10, 12 (sums 10, 18, 42, 50 >>> 2).
3. Defaults, negative data: window pixels -1, -2, -5, -6, mode=1 -> -4 (sum -14 >>> 2 = -3.5 -> -4); mode=0 -> -1. Second frame with mode toggled mid-frame -> mode change takes effect only at the next (0,0).
4. M_W=M_H=5, mode=0, data_in = 0..24 -> outputs 6, 8, 16, 18; end_op with 18; pixels 19..24 produce nothing; pixel 25 is treated as (0,0) of the next frame.
5. Defaults, in_valid and ce toggled pseudo-randomly over two frames -> identical output sequence to scenario 1 per frame, no extra or missing valid_op.
6. master_rst pulsed after pixel 6 of a frame, then 0..15 streamed -> outputs zero during reset, then exactly 5, 7, 13, 15 with end_op on 15.
